// File: rtl/datapath_controller_pkg.sv
// Shared definitions for the datapath controller: instruction fields, opcode/op
// constants, ALU operation encodings and the FSM state encoding.
package cpu_defs;
    localparam int DP_WIDTH = 16;

    localparam int OPC_LSB = 13;
    localparam int OP_LSB  = 11;
    localparam int RN_LSB  = 8;
    localparam int RD_LSB  = 5;
    localparam int SH_LSB  = 3;
    localparam int RM_LSB  = 0;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_MOVI = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WR_IMM = 3'd2,
        S_GET_A  = 3'd3,
        S_GET_B  = 3'd4,
        S_EXEC   = 3'd5,
        S_WR_REG = 3'd6
    } state_t;
endpackage

// File: rtl/datapath_controller_decoder.sv
// Combinational instruction field splitter with legality check and imm8 sign extension.
module instr_decoder
    import cpu_defs::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [15:0]      i_ir,
    output logic [2:0]       o_opcode,
    output logic [1:0]       o_op,
    output logic [2:0]       o_rn,
    output logic [2:0]       o_rd,
    output logic [2:0]       o_rm,
    output logic [1:0]       o_sh,
    output logic [WIDTH-1:0] o_sximm8,
    output logic             o_legal
);
    assign o_opcode = i_ir[OPC_LSB +: 3];
    assign o_op     = i_ir[OP_LSB  +: 2];
    assign o_rn     = i_ir[RN_LSB  +: 3];
    assign o_rd     = i_ir[RD_LSB  +: 3];
    assign o_sh     = i_ir[SH_LSB  +: 2];
    assign o_rm     = i_ir[RM_LSB  +: 3];
    assign o_sximm8 = {{(WIDTH-8){i_ir[7]}}, i_ir[7:0]};

    assign o_legal = (o_opcode == OPC_ALU) ||
                     ((o_opcode == OPC_MOV) && ((o_op == OP_MOVI) || (o_op == OP_MOVR)));
endmodule

// File: rtl/datapath_controller.sv
// Control FSM for the register/ALU datapath: latches an instruction on s while idle
// and sequences the datapath strobes; all outputs are registered.
module datapath_controller
    import cpu_defs::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic [15:0]      in,
    output logic             w,
    output logic             illegal,
    output logic [WIDTH-1:0] datapath_in,
    output logic             vsel,
    output logic [2:0]       writenum,
    output logic             write,
    output logic [2:0]       readnum,
    output logic             loada,
    output logic             loadb,
    output logic [1:0]       shift,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       ALUop,
    output logic             loadc,
    output logic             loads
);
    state_t           r_state;
    logic [15:0]      r_ir;
    state_t           w_state_nxt;
    logic [15:0]      w_ir_nxt;
    logic [2:0]       w_opcode, w_rn, w_rd, w_rm;
    logic [1:0]       w_op, w_sh;
    logic [WIDTH-1:0] w_sximm8;
    logic             w_legal, w_is_alu, w_is_cmp, w_is_mvn;

    // Decoding the next IR lets every output be registered while still matching the
    // state/IR it belongs to in the following cycle.
    instr_decoder #(.WIDTH(WIDTH)) u_dec (
        .i_ir     (w_ir_nxt),
        .o_opcode (w_opcode),
        .o_op     (w_op),
        .o_rn     (w_rn),
        .o_rd     (w_rd),
        .o_rm     (w_rm),
        .o_sh     (w_sh),
        .o_sximm8 (w_sximm8),
        .o_legal  (w_legal)
    );

    assign w_is_alu = (w_opcode == OPC_ALU);
    assign w_is_cmp = w_is_alu && (w_op == ALU_SUB);
    assign w_is_mvn = w_is_alu && (w_op == ALU_MVN);
    assign bsel     = 1'b0;

    always_comb begin
        w_state_nxt = r_state;
        w_ir_nxt    = r_ir;
        case (r_state)
            S_WAIT: if (s) begin
                w_ir_nxt    = in;
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (!w_legal)                                     w_state_nxt = S_WAIT;
                else if (w_opcode == OPC_MOV && w_op == OP_MOVI) w_state_nxt = S_WR_IMM;
                else if (w_opcode == OPC_MOV || w_is_mvn)        w_state_nxt = S_GET_B;
                else                                              w_state_nxt = S_GET_A;
            end
            S_WR_IMM: w_state_nxt = S_WAIT;
            S_GET_A:  w_state_nxt = S_GET_B;
            S_GET_B:  w_state_nxt = S_EXEC;
            S_EXEC:   w_state_nxt = w_is_cmp ? S_WAIT : S_WR_REG;
            S_WR_REG: w_state_nxt = S_WAIT;
            default:  w_state_nxt = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_WAIT;
            r_ir        <= '0;
            w           <= 1'b1;
            illegal     <= 1'b0;
            datapath_in <= '0;
            vsel        <= 1'b0;
            writenum    <= '0;
            write       <= 1'b0;
            readnum     <= '0;
            loada       <= 1'b0;
            loadb       <= 1'b0;
            shift       <= '0;
            asel        <= 1'b0;
            ALUop       <= '0;
            loadc       <= 1'b0;
            loads       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ir        <= w_ir_nxt;
            w           <= (w_state_nxt == S_WAIT);
            illegal     <= (w_state_nxt == S_DECODE) && !w_legal;
            datapath_in <= w_sximm8;
            vsel        <= (w_state_nxt == S_WR_IMM);
            writenum    <= '0;
            write       <= (w_state_nxt == S_WR_IMM) || (w_state_nxt == S_WR_REG);
            readnum     <= '0;
            loada       <= (w_state_nxt == S_GET_A);
            loadb       <= (w_state_nxt == S_GET_B);
            shift       <= '0;
            asel        <= 1'b0;
            ALUop       <= '0;
            loadc       <= 1'b0;
            loads       <= 1'b0;
            case (w_state_nxt)
                S_WR_IMM: writenum <= w_rn;
                S_GET_A:  readnum  <= w_rn;
                S_GET_B:  readnum  <= w_rm;
                S_EXEC: begin
                    shift <= w_sh;
                    ALUop <= w_is_alu ? w_op : ALU_ADD;
                    asel  <= !w_is_alu || w_is_mvn;
                    loads <= w_is_cmp;
                    loadc <= !w_is_cmp;
                end
                S_WR_REG: writenum <= w_rd;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_datapath_controller.sv
// Directed + random stimulus against a per-instruction expected strobe trace.
module tb_datapath_controller;
    typedef struct packed {
        logic        w;
        logic        illegal;
        logic [15:0] dpin;
        logic        vsel;
        logic [2:0]  writenum;
        logic        write;
        logic [2:0]  readnum;
        logic        loada;
        logic        loadb;
        logic [1:0]  shift;
        logic        asel;
        logic        bsel;
        logic [1:0]  aluop;
        logic        loadc;
        logic        loads;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset, s;
    logic [15:0] instr;
    logic        w, illegal, vsel, write, loada, loadb, asel, bsel, loadc, loads;
    logic [15:0] datapath_in;
    logic [2:0]  writenum, readnum;
    logic [1:0]  shift, ALUop;

    int          checks = 0;
    int          failures = 0;
    obs_t        q[$];
    logic [15:0] last_ir = 16'h0;

    always #5 clk = ~clk;

    datapath_controller #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .s(s), .in(instr), .w(w), .illegal(illegal),
        .datapath_in(datapath_in), .vsel(vsel), .writenum(writenum), .write(write),
        .readnum(readnum), .loada(loada), .loadb(loadb), .shift(shift), .asel(asel),
        .bsel(bsel), .ALUop(ALUop), .loadc(loadc), .loads(loads)
    );

    function automatic logic [15:0] sx8(input logic [15:0] ir);
        return {{8{ir[7]}}, ir[7:0]};
    endfunction

    function automatic obs_t quiet(input logic [15:0] ir, input logic busy);
        obs_t e;
        e      = '0;
        e.w    = !busy;
        e.dpin = sx8(ir);
        return e;
    endfunction

    // Expected per-cycle outputs from DECODE through the last busy cycle.
    task automatic push_seq(input logic [15:0] ir);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh;
        logic       movi, movr, alu, cmp, mvn;
        obs_t       e;
        opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8];
        rd  = ir[7:5];   sh = ir[4:3];   rm = ir[2:0];
        movi = (opc == 3'b110) && (op == 2'b10);
        movr = (opc == 3'b110) && (op == 2'b00);
        alu  = (opc == 3'b101);
        cmp  = alu && (op == 2'b01);
        mvn  = alu && (op == 2'b11);
        e = quiet(ir, 1'b1);
        e.illegal = !(movi || movr || alu);
        q.push_back(e);
        if (movi) begin
            e = quiet(ir, 1'b1); e.vsel = 1'b1; e.writenum = rn; e.write = 1'b1;
            q.push_back(e);
        end else if (movr || alu) begin
            if (alu && !mvn) begin
                e = quiet(ir, 1'b1); e.readnum = rn; e.loada = 1'b1;
                q.push_back(e);
            end
            e = quiet(ir, 1'b1); e.readnum = rm; e.loadb = 1'b1;
            q.push_back(e);
            e = quiet(ir, 1'b1);
            e.shift = sh;
            e.aluop = alu ? op : 2'b00;
            e.asel  = movr || mvn;
            e.loads = cmp;
            e.loadc = !cmp;
            q.push_back(e);
            if (!cmp) begin
                e = quiet(ir, 1'b1); e.writenum = rd; e.write = 1'b1;
                q.push_back(e);
            end
        end
    endtask

    // Check this cycle's outputs, then set inputs for the next edge and advance the model.
    task automatic cycle(input string tag, input logic s_i, input logic [15:0] in_i,
                         input logic r_i);
        obs_t exp, act;
        @(negedge clk);
        exp = (q.size() != 0) ? q[0] : quiet(last_ir, 1'b0);
        act = {w, illegal, datapath_in, vsel, writenum, write, readnum, loada, loadb,
               shift, asel, bsel, ALUop, loadc, loads};
        checks++;
        assert (act === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
        end
        s = s_i; instr = in_i; reset = r_i;
        if (r_i) begin
            q.delete();
            last_ir = 16'h0;
        end else if (q.size() != 0) begin
            void'(q.pop_front());
        end else if (s_i) begin
            last_ir = in_i;
            push_seq(in_i);
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 6))
            0: r[15:11] = 5'b11010;
            1: r[15:11] = 5'b11000;
            2, 3, 4: r[15:13] = 3'b101;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        reset = 1'b1; s = 1'b0; instr = 16'h0;
        @(posedge clk);
        cycle("reset_state", 1'b1, 16'hD0FB, 1'b1);
        cycle("reset_state2", 1'b0, 16'h0, 0);
        // MOV R0,#-5
        cycle("movi_accept", 1'b1, 16'hD0FB, 0);
        for (int i = 0; i < 3; i++) cycle("movi", 1'b0, 16'h0, 0);
        // ADD R3,R1,R2,LSL#1
        cycle("add_accept", 1'b1, 16'hA16A, 0);
        for (int i = 0; i < 6; i++) cycle("add", 1'b0, 16'h0, 0);
        // CMP R1,R2
        cycle("cmp_accept", 1'b1, 16'hA902, 0);
        for (int i = 0; i < 5; i++) cycle("cmp", 1'b0, 16'h0, 0);
        // MVN R4,R2
        cycle("mvn_accept", 1'b1, 16'hB882, 0);
        for (int i = 0; i < 5; i++) cycle("mvn", 1'b0, 16'h0, 0);
        // Unsupported opcode 111
        cycle("illegal_accept", 1'b1, 16'hE000, 0);
        for (int i = 0; i < 3; i++) cycle("illegal", 1'b0, 16'h0, 0);
        // Reset while the ADD is in GET_B
        cycle("rst_add_accept", 1'b1, 16'hA16A, 0);
        cycle("rst_add_decode", 1'b0, 16'h0, 0);
        cycle("rst_add_geta", 1'b0, 16'h0, 0);
        cycle("rst_add_getb", 1'b0, 16'h0, 1);
        for (int i = 0; i < 2; i++) cycle("rst_add_after", 1'b0, 16'h0, 0);
        // s held high across back-to-back MOV immediates
        for (int i = 0; i < 6; i++) cycle("b2b_movi", 1'b1, (i < 3) ? 16'hD17F : 16'hD280, 0);
        for (int i = 0; i < 3; i++) cycle("b2b_tail", 1'b0, 16'h0, 0);
        for (int i = 0; i < 800; i++)
            cycle("random", ($urandom_range(0, 2) != 0), rand_instr(),
                  ($urandom_range(0, 39) == 0));
        cycle("final", 1'b0, 16'h0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
